// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-request types for the fetch/mem bus arbiter.
// Holds the request struct, the bus mode encodings and the arbiter state enum.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } memreq_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_e;

  localparam memreq_t MEMREQ_RESET = '{mode: MEMREQ_READ, addr: '0, wdata: '0, wstrb: '0};

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory request/response channel: pulse request with fields, pulse response with data.
// "master" issues requests, "slave" serves them.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic              request_enable;
  logic              mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              response_enable;
  logic [DATA_W-1:0] data;

  modport master (
    output request_enable, mode, addr, wdata, wstrb,
    input  response_enable, data
  );

  modport slave (
    input  request_enable, mode, addr, wdata, wstrb,
    output response_enable, data
  );

endinterface

// File: rtl/mem_bus_arbiter_memreq_slot.sv
// Single-entry pending request register for one arbiter port.
// A pulse is captured only when the slot is empty and the port has nothing in flight.
module memreq_slot
  import mem_bus_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    req_valid,
  input  memreq_t req,
  input  logic    busy,
  input  logic    clear,
  output logic    valid,
  output memreq_t entry,
  output logic    overflow
);

  logic    valid_q, valid_d;
  memreq_t entry_q, entry_d;

  always_comb begin
    valid_d  = valid_q;
    entry_d  = entry_q;
    // A second pulse while this port already owns an entry is dropped and flagged.
    overflow = req_valid && (valid_q || busy);
    if (clear) begin
      valid_d = 1'b0;
    end else if (req_valid && !valid_q && !busy) begin
      valid_d = 1'b1;
      entry_d = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      entry_q <= MEMREQ_RESET;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid = valid_q;
  assign entry = entry_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port and the data port, one transaction
// at a time, routing each response back to the port that issued it.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic                     clk,
  input  logic                     rstn,
  mem_bus_arbiter_if.slave         if_port,
  mem_bus_arbiter_if.slave         d_port,
  mem_bus_arbiter_if.master        bus,
  output logic                     protocol_error
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  memreq_t           bus_req_q, bus_req_d;
  logic              request_enable_q, request_enable_d;
  logic              if_resp_q, if_resp_d;
  logic              d_resp_q, d_resp_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              protocol_error_q, protocol_error_d;

  memreq_t if_in, d_in, if_entry, d_entry, if_cand_req, d_cand_req;
  logic    if_valid, d_valid, if_overflow, d_overflow;
  logic    if_cand, d_cand, grant_if, grant_d;
  logic    if_busy, d_busy;

  assign if_busy = (state_q == ARB_BUSY_IF);
  assign d_busy  = (state_q == ARB_BUSY_D);

  always_comb begin
    if_in = '{mode: if_port.mode, addr: if_port.addr, wdata: if_port.wdata, wstrb: if_port.wstrb};
    d_in  = '{mode: d_port.mode, addr: d_port.addr, wdata: d_port.wdata, wstrb: d_port.wstrb};
  end

  memreq_slot u_if_slot (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (if_port.request_enable),
    .req       (if_in),
    .busy      (if_busy),
    .clear     (grant_if),
    .valid     (if_valid),
    .entry     (if_entry),
    .overflow  (if_overflow)
  );

  memreq_slot u_d_slot (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (d_port.request_enable),
    .req       (d_in),
    .busy      (d_busy),
    .clear     (grant_d),
    .valid     (d_valid),
    .entry     (d_entry),
    .overflow  (d_overflow)
  );

  // A pending entry takes precedence over a same-cycle pulse on that port (the pulse overflows).
  always_comb begin
    if_cand     = if_valid || if_port.request_enable;
    d_cand      = d_valid || d_port.request_enable;
    if_cand_req = if_valid ? if_entry : if_in;
    d_cand_req  = d_valid ? d_entry : d_in;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (if_cand && d_cand) begin
        if (DATA_PRIORITY || (last_grant_q == GRANT_IF)) begin
          grant_d = 1'b1;
        end else begin
          grant_if = 1'b1;
        end
      end else begin
        grant_if = if_cand;
        grant_d  = d_cand;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    bus_req_d        = bus_req_q;
    request_enable_d = 1'b0;
    if_resp_d        = 1'b0;
    d_resp_d         = 1'b0;
    if_data_d        = if_data_q;
    d_data_d         = d_data_q;
    protocol_error_d = protocol_error_q || if_overflow || d_overflow;
    case (state_q)
      ARB_IDLE: begin
        if (bus.response_enable) begin
          protocol_error_d = 1'b1;
        end
        if (grant_if) begin
          bus_req_d        = if_cand_req;
          request_enable_d = 1'b1;
          state_d          = ARB_BUSY_IF;
        end else if (grant_d) begin
          bus_req_d        = d_cand_req;
          request_enable_d = 1'b1;
          state_d          = ARB_BUSY_D;
        end
      end
      ARB_BUSY_IF: begin
        if (bus.response_enable) begin
          if_data_d    = bus.data;
          if_resp_d    = 1'b1;
          last_grant_d = GRANT_IF;
          state_d      = ARB_IDLE;
        end
      end
      ARB_BUSY_D: begin
        if (bus.response_enable) begin
          d_data_d     = bus.data;
          d_resp_d     = 1'b1;
          last_grant_d = GRANT_D;
          state_d      = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= ARB_IDLE;
      last_grant_q     <= GRANT_D;
      bus_req_q        <= MEMREQ_RESET;
      request_enable_q <= 1'b0;
      if_resp_q        <= 1'b0;
      d_resp_q         <= 1'b0;
      if_data_q        <= '0;
      d_data_q         <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      bus_req_q        <= bus_req_d;
      request_enable_q <= request_enable_d;
      if_resp_q        <= if_resp_d;
      d_resp_q         <= d_resp_d;
      if_data_q        <= if_data_d;
      d_data_q         <= d_data_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign bus.request_enable     = request_enable_q;
  assign bus.mode               = bus_req_q.mode;
  assign bus.addr               = bus_req_q.addr;
  assign bus.wdata              = bus_req_q.wdata;
  assign bus.wstrb              = bus_req_q.wstrb;
  assign if_port.response_enable = if_resp_q;
  assign if_port.data           = if_data_q;
  assign d_port.response_enable = d_resp_q;
  assign d_port.data            = d_data_q;
  assign protocol_error         = protocol_error_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the single core memory bus between the instruction-fetch stage and the mem (load/store/atomic) stage. Each requester issues one-cycle request pulses with mode/addr/wdata/wstrb. The arbiter latches requests, grants one transaction at a time to the downstream bus, and routes the one-cycle response back to the issuing port. It sits between the fetch/mem stages and the bus/cache interface.

## Interface
- `DATA_PRIORITY`, default 1: 1 = data port always wins a simultaneous contest; 0 = round-robin.
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `if_request_enable`  in  1  fetch request pulse
- `if_mode`  in  1  `MEMREQ_READ`/`MEMREQ_WRITE`
- `if_addr`  in  32  address
- `if_wdata`  in  32  write data
- `if_wstrb`  in  4  byte strobes
- `if_response_enable`  out  1  fetch response pulse
- `if_data`  out  32  fetch read data
- `d_request_enable`, `d_mode`, `d_addr`, `d_wdata`, `d_wstrb`, `d_response_enable`, `d_data`: same widths and directions as the `if_*` ports, for the data port.
- `request_enable`  out  1  downstream request pulse
- `mode`  out  1  downstream mode
- `addr`  out  32  downstream address
- `wdata`  out  32  downstream write data
- `wstrb`  out  4  downstream strobes
- `response_enable`  in  1  downstream response pulse
- `data`  in  32  downstream read data
- `protocol_error`  out  1  sticky violation flag

## Operation
- Per port: a pending register holding `{valid, mode, addr, wdata, wstrb}`. It is captured on a request pulse and cleared when that port is granted.
- States:
  - `IDLE`: no transaction in flight.
  - `BUSY_IF`: fetch transaction in flight.
  - `BUSY_D`: data transaction in flight.
- `IDLE` evaluates two candidates: the latched pending entry for each port, and the port's incoming pulse in the current cycle (bypass).
  - One candidate: grant it, drive the bus fields from that port, pulse `request_enable`, and go to `BUSY_x`.
  - Both candidates with `DATA_PRIORITY`=1: grant data.
  - Both candidates with `DATA_PRIORITY`=0: grant the port opposite to `last_grant`. After reset `last_grant` = data, so fetch goes first.
  - The losing port stays pending.
- `BUSY_x`: `addr`/`mode`/`wdata`/`wstrb` are held stable. On `response_enable`:
  - Register `data` into `x_data`.
  - Pulse `x_response_enable`.
  - Update `last_grant` to x.
  - Return to `IDLE`.
- Writes also return a response pulse. `x_data` then carries the bus `data` value unchanged.
- `x_data` holds its value until the next response to that port.
- Protocol violations set `protocol_error`, which stays set until reset. Each violation is dropped:
  - A request pulse on a port whose entry is already pending or in flight: the new request is dropped and the original is preserved.
  - `response_enable` while in `IDLE`: the response is dropped.
- Requests arriving during `BUSY` are latched normally and served after the current response.

## Timing
- Reset values:
  - `request_enable`=0, `if_response_enable`=0, `d_response_enable`=0, `protocol_error`=0.
  - `mode`=`MEMREQ_READ`, `addr`/`wdata`/`if_data`/`d_data`=0, `wstrb`=0.
  - Pending valid bits cleared, state `IDLE`, `last_grant`=data.
- Reset mid-transaction abandons it; a later downstream response hits `IDLE` and sets `protocol_error`.
- All outputs are registered.
- Request pulse in cycle N with the arbiter `IDLE` and no contest: `request_enable`=1 in cycle N+1 only.
- `response_enable` in cycle M: `x_response_enable`=1 in cycle M+1 only, with `x_data` valid in M+1. State is `IDLE` in M+1.
- A pending loser gets `request_enable` in M+2, one idle bus cycle after the response.
- `request_enable` is never high for two consecutive cycles.
- At most one transaction is outstanding on the bus.
- `response_enable` in the same cycle as the grant edge is impossible by protocol. If the bus asserts it in the cycle `request_enable` is high, it is accepted as the response.

## Structure
- `MEMREQ_READ`/`MEMREQ_WRITE` and a `memreq` struct `{mode, addr, wdata, wstrb}` go in the shared `def.sv` package.
- The arbiter state enum also goes in `def.sv`.
- One natural sub-module: `memreq_slot`, a single-entry pending register with capture/clear/overflow-detect. It is instantiated twice.

## Test plan
- Single fetch read:
  - Stimulus: `if_request_enable` pulse with addr=0x100 in cycle 0; bus responds data=0xDEADBEEF in cycle 3.
  - Response: `request_enable` in cycle 1, addr=0x100, mode=READ; `if_response_enable` with `if_data`=0xDEADBEEF in cycle 4.
- Simultaneous contest with `DATA_PRIORITY`=1:
  - Stimulus: fetch read 0x200 and data write 0x3000 (wdata=0x11223344, wstrb=4'b0011) pulsed in the same cycle.
  - Response: data write is issued first; fetch `request_enable` follows exactly 2 cycles after the data response.
- Round-robin with `DATA_PRIORITY`=0:
  - Stimulus: three consecutive simultaneous contests.
  - Response: grant order is fetch, data, fetch, data, fetch, data.
- Request during busy:
  - Stimulus: data request pulses while a fetch transaction is in flight.
  - Response: the data request is latched; its bus fields appear unchanged after the fetch response, and `protocol_error` stays 0.
- Violations:
  - Stimulus: a second fetch pulse while fetch is pending.
  - Response: dropped, original addr issued, `protocol_error`=1.
  - Stimulus: `response_enable` in `IDLE`.
  - Response: no port response, `protocol_error`=1.
- Reset mid-transaction:
  - Stimulus: assert `rstn`=0 one cycle during `BUSY_D`.
  - Response: all outputs at reset values. A following bus response produces no `d_response_enable` and sets `protocol_error`=1.
